perf_counter_bank: RTL

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_stats_pkg.sv | 18 +
 rtl/perf_counter_bank_if.sv | 28 ++
 rtl/perf_counter.sv | 42 ++++
 rtl/perf_counter_bank.sv | 105 ++++++++++
 4 files changed

// File: rtl/perf_stats_pkg.sv
// Shared types and default parameters for the performance counter bank.
package perf_stats_pkg;

    localparam int DEF_NUM_COUNTERS  = 8;
    localparam int DEF_COUNTER_WIDTH = 64;
    localparam bit DEF_SATURATE      = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } dump_state_t;

    // Index width never drops below one bit, so a single-counter bank still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Snapshot dump stream between the counter bank (slave) and its consumer (master).
interface perf_counter_bank_if
    import perf_stats_pkg::*;
#(
    parameter int NUM_COUNTERS  = DEF_NUM_COUNTERS,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
);
    localparam int IDX_W = idx_width(NUM_COUNTERS);

    logic                     dump_req;
    logic                     dump_ready;
    logic                     dump_busy;
    logic                     dump_valid;
    logic [IDX_W-1:0]         dump_idx;
    logic [COUNTER_WIDTH-1:0] dump_data;
    logic                     dump_last;

    modport master (
        output dump_req, dump_ready,
        input  dump_busy, dump_valid, dump_idx, dump_data, dump_last
    );

    modport slave (
        input  dump_req, dump_ready,
        output dump_busy, dump_valid, dump_idx, dump_data, dump_last
    );

endinterface

// File: rtl/perf_counter.sv
// Single event counter with sticky overflow; saturates or wraps at all-ones.
module perf_counter
    import perf_stats_pkg::*;
#(
    parameter int WIDTH    = DEF_COUNTER_WIDTH,
    parameter bit SATURATE = DEF_SATURATE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             overflow
);

    logic [WIDTH-1:0] r_value;
    logic             r_overflow;

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_value    <= '0;
            r_overflow <= 1'b0;
        end else if (inc) begin
            if (&r_value) begin
                r_overflow <= 1'b1;
                if (!SATURATE) begin
                    r_value <= '0;
                end
            end else begin
                r_value <= r_value + WIDTH'(1);
            end
        end
    end

    assign value    = r_value;
    assign overflow = r_overflow;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with a snapshot-and-stream dump port.
module perf_counter_bank
    import perf_stats_pkg::*;
#(
    parameter int NUM_COUNTERS  = DEF_NUM_COUNTERS,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter bit SATURATE      = DEF_SATURATE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_COUNTERS-1:0] inc,
    input  logic                    clear,
    output logic [NUM_COUNTERS-1:0] overflow,
    perf_counter_bank_if.slave      dump_if
);

    localparam int               IDX_W    = idx_width(NUM_COUNTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTERS - 1);

    logic [COUNTER_WIDTH-1:0] w_value [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] r_snap  [NUM_COUNTERS];
    dump_state_t              r_state;
    dump_state_t              w_state_next;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         w_idx_next;
    logic                     w_snap_load;
    logic                     w_streaming;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_counter
            perf_counter #(
                .WIDTH    (COUNTER_WIDTH),
                .SATURATE (SATURATE)
            ) u_counter (
                .clk      (clk),
                .reset    (reset),
                .inc      (inc[gi]),
                .clear    (clear),
                .value    (w_value[gi]),
                .overflow (overflow[gi])
            );
        end
    endgenerate

    // Snapshot samples the counter registers, so same-cycle inc/clear are not yet visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_snap_load) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_snap[i] <= w_value[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_snap_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dump_if.dump_req) begin
                    w_state_next = ST_STREAM;
                    w_idx_next   = '0;
                    w_snap_load  = 1'b1;
                end
            end
            ST_STREAM: begin
                if (dump_if.dump_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = ST_IDLE;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    assign w_streaming        = (r_state == ST_STREAM);
    assign dump_if.dump_valid = w_streaming;
    assign dump_if.dump_busy  = w_streaming;
    assign dump_if.dump_idx   = r_idx;
    assign dump_if.dump_last  = w_streaming && (r_idx == LAST_IDX);
    assign dump_if.dump_data  = w_streaming ? r_snap[r_idx] : '0;

endmodule
